// File: rtl/baud_gen_frac.sv
// baud_gen_frac -- fractional-N baud tick generator for a UART.
//
// A period counter produces one sample_tick every P clocks, where P is the
// active integer divisor, optionally stretched by one clock whenever a
// fractional phase accumulator carries.  Every OVERSAMPLE sample_ticks a
// bit_tick is produced in the same cycle as the wrapping sample_tick.
//
// Optional feature macro: BAUD_FRAC_EN
//   defined   -> fractional accumulator and frac_in path compiled in
//   undefined -> frac_in / RESET_FRAC ignored, P is always the integer divisor
//
// Parameters
//   DIV_W       integer divisor width
//   FRAC_W      fractional divisor width (sixteenths at default)
//   OVERSAMPLE  sample_ticks per bit_tick (>= 2)
//   RESET_DIV   integer divisor after reset (>= 2)
//   RESET_FRAC  fractional divisor after reset
//
// Ports
//   clk           single clock
//   rst           synchronous active-high reset, highest priority
//   en            run enable; counters hold while low
//   phase_clr     restart bit phase (RX start-bit alignment)
//   load          single-cycle request to capture div_in / frac_in
//   div_in        requested integer divisor
//   frac_in       requested fractional divisor
//   sample_tick   oversample tick, one clk wide
//   bit_tick      bit-rate tick, one clk wide
//   load_pending  accepted divisor waiting for a period boundary
//   div_err       one-cycle pulse on a rejected load (div_in < 2)

module baud_gen_frac #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVERSAMPLE = 16,
  parameter int RESET_DIV  = 325,
  parameter int RESET_FRAC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              phase_clr,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_in,
  input  logic [FRAC_W-1:0] frac_in,
  output logic              sample_tick,
  output logic              bit_tick,
  output logic              load_pending,
  output logic              div_err
);

  // One extra bit so that divisor+1 can never overflow the counter.
  localparam int CW  = DIV_W + 1;
  localparam int OSW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    last;
  logic [OSW-1:0]   os_cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_pend;
  logic             carry;       // current period is stretched by one clk
  logic             period_end;
  logic             load_ok;
  logic             load_bad;
  logic             activate;

  assign load_ok  = load && (div_in >= DIV_W'(2));
  assign load_bad = load && !load_ok;

  // Last count of the current period: P-1 = div + carry - 1.  div >= 2 is
  // guaranteed, so this never underflows.
  assign last = {1'b0, div_act} + {{DIV_W{1'b0}}, carry} - CW'(1);

  // ">=" rather than "==": a divisor swapped in while disabled may be
  // shorter than the count already reached; the period then ends on the
  // first enabled edge instead of running off to counter wrap.
  assign period_end = en && !phase_clr && (cnt >= last);

  // The pending divisor is taken over at a period end, at phase_clr, or
  // straight away while the generator is stopped.  Only an already pending
  // value is promoted, so a load coincident with a period end waits for the
  // following one.
  assign activate = load_pending && (phase_clr || !en || period_end);

  // ------------------------------------------------------------------
  // Period counter, oversample counter, ticks, divisor registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      os_cnt       <= '0;
      div_act      <= DIV_W'(RESET_DIV);
      div_pend     <= '0;
      load_pending <= 1'b0;
      sample_tick  <= 1'b0;
      bit_tick     <= 1'b0;
      div_err      <= 1'b0;
    end else begin
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
      div_err     <= load_bad;

      if (phase_clr) begin
        // Restart phase; any tick due this cycle is dropped.
        cnt    <= '0;
        os_cnt <= '0;
      end else if (period_end) begin
        cnt         <= '0;
        sample_tick <= 1'b1;
        if (os_cnt == OS_LAST) begin
          os_cnt   <= '0;
          bit_tick <= 1'b1;
        end else begin
          os_cnt <= os_cnt + OSW'(1);
        end
      end else if (en) begin
        cnt <= cnt + CW'(1);
      end

      if (activate) div_act <= div_pend;

      // Last valid load wins; a fresh load outranks the clear from promotion.
      if (load_ok) begin
        div_pend     <= div_in;
        load_pending <= 1'b1;
      end else if (activate) begin
        load_pending <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Fractional accumulator
  // ------------------------------------------------------------------
`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_act;
  logic [FRAC_W-1:0] frac_pend;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;

  // Sum uses the fraction that was active for the period just finished.
  assign acc_sum = {1'b0, acc} + {1'b0, frac_act};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      carry     <= 1'b0;
      frac_act  <= FRAC_W'(RESET_FRAC);
      frac_pend <= '0;
    end else begin
      if (phase_clr) begin
        acc   <= '0;
        carry <= 1'b0;
      end else if (period_end) begin
        acc   <= acc_sum[FRAC_W-1:0];
        carry <= acc_sum[FRAC_W];
      end
      if (activate) frac_act  <= frac_pend;
      if (load_ok)  frac_pend <= frac_in;
    end
  end
`else
  // Integer-only build: the fraction path does not exist.
  logic unused_frac;
  assign unused_frac = ^{frac_in, FRAC_W'(RESET_FRAC)};
  assign carry       = 1'b0;
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac.  A cycle-level behavioural model
// (elapsed-clocks / period-length arithmetic) predicts ticks, error pulses
// and load_pending; predictions are queued with the clock edge at which they
// must appear, and an independent monitor compares them on the falling edge.

module tb_baud_gen_frac;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OS     = 16;
  localparam int RD     = 325;
  localparam int RF     = 8;
`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              phase_clr = 1'b0;
  logic              load = 1'b0;
  logic [DIV_W-1:0]  div_in = '0;
  logic [FRAC_W-1:0] frac_in = '0;
  logic              sample_tick, bit_tick, load_pending, div_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int cyc; bit bt; } tick_t;
  typedef struct { int cyc; bit lp; } lp_t;
  tick_t tq[$];
  int    eq[$];
  lp_t   lpq[$];

  // model state
  int m_div, m_frac, p_div, p_frac, m_e, m_acc, m_carry, m_os, m_ticks;
  bit m_pend;

  baud_gen_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS),
                  .RESET_DIV(RD), .RESET_FRAC(RF)) dut (
    .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr), .load(load),
    .div_in(div_in), .frac_in(frac_in), .sample_tick(sample_tick),
    .bit_tick(bit_tick), .load_pending(load_pending), .div_err(div_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Predict what the next clock edge does with the inputs now applied.
  task automatic model_step();
    int stamp = cyc + 1;
    bit tick = 1'b0;
    bit bt = 1'b0;
    int s;
    if (rst) begin
      m_div = RD; m_frac = FRAC_ON ? RF : 0; m_pend = 1'b0;
      m_e = 0; m_acc = 0; m_carry = 0; m_os = 0;
    end else begin
      if (load && div_in < 2) eq.push_back(stamp);
      if (phase_clr) begin
        if (m_pend) begin m_div = p_div; m_frac = p_frac; m_pend = 1'b0; end
        m_e = 0; m_acc = 0; m_carry = 0; m_os = 0;
      end else if (!en) begin
        if (m_pend) begin m_div = p_div; m_frac = p_frac; m_pend = 1'b0; end
      end else if (m_e + 1 >= m_div + m_carry) begin
        tick = 1'b1; m_e = 0; m_ticks++;
        if (m_os == OS - 1) begin bt = 1'b1; m_os = 0; end else m_os++;
        if (FRAC_ON) begin
          s = m_acc + m_frac;
          m_carry = s / (1 << FRAC_W);
          m_acc = s % (1 << FRAC_W);
        end
        if (m_pend) begin m_div = p_div; m_frac = p_frac; m_pend = 1'b0; end
      end else begin
        m_e++;
      end
      if (load && div_in >= 2) begin
        p_div = int'(div_in); p_frac = FRAC_ON ? int'(frac_in) : 0; m_pend = 1'b1;
      end
    end
    if (tick) tq.push_back('{stamp, bt});
    lpq.push_back('{stamp, m_pend});
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Run enabled until the model is one clock from a period end with the
  // given divisor and elapsed count; a timeout is a failed comparison.
  task automatic wait_count(input int div, input int e, input int bound, input string tag);
    int n = 0;
    while (!(m_div == div && m_carry == 0 && m_e == e && !m_pend) && n < bound) begin
      cycle(); n++;
    end
    checks++;
    if (n >= bound) begin
      failures++;
      $display("FAIL %s: wait timeout after %0d cycles (need count %0d)", tag, n, e);
    end
  endtask

  // ---------------- monitor ----------------
  tick_t mt;
  lp_t   ml;
  int    me;
  always @(negedge clk) begin
    if (lpq.size() > 0 && lpq[0].cyc == cyc) begin
      ml = lpq.pop_front();
      checks++;
      if (load_pending !== ml.lp) begin
        failures++;
        $display("FAIL load_pending @%0d: got %b want %b", cyc, load_pending, ml.lp);
      end
    end
    while (tq.size() > 0 && tq[0].cyc < cyc) begin
      mt = tq.pop_front();
      checks++; failures++;
      $display("FAIL sample_tick missed: want tick @%0d", mt.cyc);
    end
    if (sample_tick === 1'b1) begin
      checks++;
      if (tq.size() == 0 || tq[0].cyc != cyc) begin
        failures++;
        $display("FAIL sample_tick spurious @%0d: got 1 want 0", cyc);
      end else begin
        mt = tq.pop_front();
        if (bit_tick !== mt.bt) begin
          failures++;
          $display("FAIL bit_tick @%0d: got %b want %b", cyc, bit_tick, mt.bt);
        end
      end
    end else if (bit_tick !== 1'b0) begin
      checks++; failures++;
      $display("FAIL bit_tick without sample_tick @%0d: got %b want 0", cyc, bit_tick);
    end
    while (eq.size() > 0 && eq[0] < cyc) begin
      me = eq.pop_front();
      checks++; failures++;
      $display("FAIL div_err missed: want pulse @%0d", me);
    end
    if (div_err === 1'b1) begin
      checks++;
      if (eq.size() == 0 || eq[0] != cyc) begin
        failures++;
        $display("FAIL div_err spurious @%0d: got 1 want 0", cyc);
      end else begin
        me = eq.pop_front();
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int start;
    m_ticks = 0;
    rst = 1'b1;
    run(3);
    checks++;
    if ({sample_tick, bit_tick, load_pending, div_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state: got %b want 0000",
               {sample_tick, bit_tick, load_pending, div_err});
    end
    rst = 1'b0;
    en  = 1'b1;

    // default divisor, 32 sample periods
    start = m_ticks;
    for (int i = 0; i < 12000 && m_ticks - start < 32; i++) cycle();
    checks++;
    if (m_ticks - start < 32) begin
      failures++;
      $display("FAIL default_run: got %0d ticks want 32", m_ticks - start);
    end

    // switch to div=4 mid-period
    run(100);
    div_in = 16'd4; frac_in = 4'd0; load = 1'b1;
    cycle();
    load = 1'b0;
    run(400);

    // rejected load
    div_in = 16'd1; load = 1'b1;
    cycle();
    load = 1'b0;
    run(20);

    // phase_clr on the last count of a div=4 period
    wait_count(4, 3, 40, "phase_clr_align");
    phase_clr = 1'b1;
    cycle();
    phase_clr = 1'b0;
    run(80);

    // enable dropped for 10 clk at count 2
    wait_count(4, 2, 40, "en_hold_align");
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(20);

    // reset while a load is pending
    div_in = 16'd7; load = 1'b1;
    cycle();
    load = 1'b0;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(340);

    // randomized traffic
    div_in = 16'd5; load = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      rst       = ($urandom_range(1999) == 0);
      en        = ($urandom_range(9) != 0);
      phase_clr = ($urandom_range(59) == 0);
      load      = ($urandom_range(24) == 0);
      div_in    = DIV_W'($urandom_range(12));
      frac_in   = FRAC_W'($urandom_range(15));
      cycle();
    end
    rst = 1'b0; en = 1'b1; phase_clr = 1'b0; load = 1'b0;
    run(30);

    @(negedge clk);
    #1;
    checks++;
    if (tq.size() != 0 || eq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d ticks / %0d errs outstanding want 0", tq.size(), eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16, meaning integer divisor width.
REQ-002 The block SHALL have parameter FRAC_W, default 4, meaning fractional divisor width (sixteenths at default).
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, meaning sample_ticks per bit_tick (>=2).
REQ-004 The block SHALL have parameter RESET_DIV, default 325, meaning integer divisor after reset (50 MHz, 9600 baud x16).
REQ-005 The block SHALL have parameter RESET_FRAC, default 8, meaning fractional divisor after reset.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the single FPGA clock.
REQ-007 The block SHALL have port rst, input, 1 bit, meaning reset, synchronous to clk and active-high.
REQ-008 The block SHALL have port en, input, 1 bit, meaning run enable.
REQ-009 The block SHALL have port phase_clr, input, 1 bit, meaning restart the bit phase (RX start-bit alignment).
REQ-010 The block SHALL have port load, input, 1 bit, meaning single-cycle request to capture div_in/frac_in.
REQ-011 The block SHALL have port div_in, input, DIV_W bits, meaning the requested integer divisor.
REQ-012 The block SHALL have port frac_in, input, FRAC_W bits, meaning the requested fractional divisor.
REQ-013 The block SHALL have port sample_tick, output, 1 bit, meaning the oversample tick, one clk wide.
REQ-014 The block SHALL have port bit_tick, output, 1 bit, meaning the bit-rate tick, one clk wide.
REQ-015 The block SHALL have port load_pending, output, 1 bit, meaning an accepted divisor is waiting for a period boundary.
REQ-016 The block SHALL have port div_err, output, 1 bit, meaning a one-cycle pulse on a rejected load.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 Period counter SHALL count 0..P-1 while en=1, where P = active integer divisor, or that divisor+1 when the fractional accumulator carries.
REQ-019 At each period end, accumulator (FRAC_W bits) SHALL add the active fraction modulo 2^FRAC_W; the carry-out SHALL lengthen the next period by one clk.
REQ-020 sample_tick SHALL be high for exactly the one cycle following the edge at which the counter reaches P-1; latency from rst release to the first tick SHALL be P clk edges.
REQ-021 An oversample counter SHALL count sample_ticks 0..OVERSAMPLE-1; bit_tick SHALL assert in the same cycle as the sample_tick that wraps it to 0.
REQ-022 With en=0, counter, accumulator and oversample count SHALL hold, and both ticks SHALL be 0 the next cycle.
REQ-023 phase_clr=1 SHALL zero the counter and oversample count and SHALL suppress any tick due that cycle; the accumulator SHALL be zeroed.
REQ-024 A load with div_in<2 SHALL be rejected: div_err=1 for one cycle, active and pending values unchanged.
REQ-025 A valid load SHALL latch into a pending register and set load_pending=1.
REQ-026 The pending value SHALL become active at the next period end, at phase_clr, or immediately when en=0; load_pending SHALL clear in that same cycle.
REQ-027 A valid load that arrives while load_pending=1 SHALL overwrite the pending value (last load wins).
REQ-028 A load coincident with a period end SHALL become active at the following period end, not the current one.
REQ-029 Counter width SHALL be DIV_W+1 bits so that divisor+1 never overflows.

Reset
REQ-030 rst SHALL take priority over all inputs.
REQ-031 On rst, counter, accumulator and oversample count SHALL be 0, and active divisor SHALL be RESET_DIV/RESET_FRAC.
REQ-032 On rst, sample_tick, bit_tick, load_pending and div_err SHALL be 0, and the pending request SHALL be discarded.
REQ-033 Reset asserted mid-period SHALL restart timing from count 0 on the first cycle after release.

Configuration
REQ-034 With macro BAUD_FRAC_EN defined, the accumulator and frac_in path SHALL be compiled in per REQ-019.
REQ-035 Without BAUD_FRAC_EN, frac_in and RESET_FRAC SHALL be ignored, no accumulator SHALL exist, and P SHALL always equal the integer divisor.

Verification
REQ-036 Reset default divisor 325, frac 8, en=1, 32 sample periods -> periods alternate 325/326 clk, 1 bit_tick per 16 sample_ticks.
REQ-037 Load div_in=4, frac_in=0, mid-period -> load_pending=1 until the current period ends, then sample_tick every 4 clk.
REQ-038 Load div_in=1 -> div_err single-cycle pulse, load_pending stays 0, period unchanged.
REQ-039 div=4 running, phase_clr on cycle where the counter is 3 -> no tick that cycle, next sample_tick 4 clk later, bit_tick after 16 sample_ticks.
REQ-040 en=0 for 10 clk mid-period at count 2, div=4 -> no ticks, then the tick 2 clk after en returns to 1.
REQ-041 rst pulsed with load_pending=1 -> pending value discarded, first sample_tick 325 (or 326 when carrying) clk after release.
